// File: rtl/fulladder_pipeline.sv
// -----------------------------------------------------------------------------
// fulladder_pipeline
//
// Pipelined add/subtract unit. The WIDTH-bit operands are cut into STAGES
// chunks of CHUNK bits; pipeline stage k resolves chunk k and registers the
// carry for stage k+1. Upper operand chunks ride along in skew registers and
// finished lower result chunks ride along in deskew registers, so a complete
// result leaves the last stage STAGES cycles after the operands were accepted.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   unit accepts a beat this cycle
//   a, b       WIDTH-bit operands
//   carry_in   carry (add) or borrow (sub) in
//   sub        0 = a + b + carry_in, 1 = a - b - carry_in
//   out_valid  result beat valid
//   out_ready  consumer accepts the result
//   sum        WIDTH-bit result
//   carry_out  final carry; in subtract mode 1 means "no borrow"
//   overflow   two's-complement signed overflow
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high. The producer side samples a/b/carry_in/sub only
// on in_valid & in_ready. Once out_valid is high, out_valid/sum/carry_out/
// overflow hold until out_ready is seen high. A stalled output
// (out_valid & !out_ready) freezes the whole pipeline and drops in_ready;
// out_ready -> in_ready is the only combinational path through the block.
// -----------------------------------------------------------------------------
module fulladder_pipeline #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CHUNK = WIDTH / STAGES;

    generate
        if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
            $error("fulladder_pipeline: WIDTH must be >= 2 and divisible by STAGES (1..WIDTH)");
        end
    endgenerate

    // Pipeline registers, index k = output register of stage k.
    // a_q/b_q carry the not-yet-consumed upper chunks (skew),
    // res_q carries the already-resolved lower chunks (deskew).
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  res_q [STAGES];
    logic              ovf_q;

    // Per-stage inputs and next-state values.
    logic [STAGES-1:0] stg_v;
    logic [STAGES-1:0] stg_c;
    logic [WIDTH-1:0]  stg_a [STAGES];
    logic [WIDTH-1:0]  stg_b [STAGES];
    logic [WIDTH-1:0]  stg_r [STAGES];
    logic [WIDTH-1:0]  nxt_r [STAGES];
    logic [STAGES-1:0] nxt_c;
    logic [CHUNK:0]    chunk_sum [STAGES];
    logic              nxt_ovf;

    logic              stall;
    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;

    // Subtraction is a + ~b + !borrow_in, so the inversion happens once at entry.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? ~carry_in : carry_in;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    always_comb begin
        // Stage 0 takes the producer beat; a bubble enters with zeroed data.
        stg_v[0] = in_valid;
        stg_c[0] = in_valid & cin_eff;
        stg_a[0] = in_valid ? a : '0;
        stg_b[0] = in_valid ? b_eff : '0;
        stg_r[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            stg_v[k] = valid_q[k-1];
            stg_c[k] = carry_q[k-1];
            stg_a[k] = a_q[k-1];
            stg_b[k] = b_q[k-1];
            stg_r[k] = res_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            chunk_sum[k] = {1'b0, stg_a[k][k*CHUNK +: CHUNK]}
                         + {1'b0, stg_b[k][k*CHUNK +: CHUNK]}
                         + {{CHUNK{1'b0}}, stg_c[k]};
            nxt_r[k] = stg_r[k];
            nxt_r[k][k*CHUNK +: CHUNK] = chunk_sum[k][CHUNK-1:0];
            nxt_c[k] = chunk_sum[k][CHUNK];
        end

        // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c_in.
        nxt_ovf = stg_a[STAGES-1][WIDTH-1] ^ stg_b[STAGES-1][WIDTH-1]
                ^ nxt_r[STAGES-1][WIDTH-1] ^ nxt_c[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                res_q[k] <= '0;
            end
        end else if (!stall) begin
            valid_q <= stg_v;
            carry_q <= nxt_c;
            ovf_q   <= nxt_ovf;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= stg_a[k];
                b_q[k]   <= stg_b[k];
                res_q[k] <= nxt_r[k];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign sum       = res_q[STAGES-1];
    assign carry_out = carry_q[STAGES-1];
    assign overflow  = ovf_q;

endmodule

// File: doc/fulladder_pipeline.md
Name: fulladder_pipeline

Overview:
- Parametrised, pipelined add/subtract unit; next generation of the ripple full-adder chain.
- WIDTH-bit operands are split into STAGES equal chunks. Each pipeline stage resolves one chunk and registers the carry into the next stage.
- One result per cycle at full throughput, with a valid/ready handshake on both sides.
- Sits between operand producers and the datapath, replacing long combinational ripple chains where timing fails.

Parameters:
- WIDTH, 32: operand and result width in bits. Must be ≥ 2.
- STAGES, 4: pipeline stages (chunks). 1 ≤ STAGES ≤ WIDTH, and WIDTH % STAGES == 0. Elaboration fails otherwise.
- CHUNK, WIDTH/STAGES: derived local parameter, bits per stage. Not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- carry_in  input  1  carry (add) or borrow (sub) in.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- carry_out  output  1  final carry. In sub mode, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Arithmetic, evaluated modulo 2^WIDTH:
  - sub=0: {carry_out,sum} = a + b + carry_in.
  - sub=1: {carry_out,sum} = a + ~b + !carry_in, i.e. a − b − carry_in.
- overflow = carry into MSB XOR carry out of MSB, computed in the final stage.
- Stage k (0..STAGES−1):
  - Adds chunk k of a and of (b, inverted when sub=1), plus the registered carry from stage k−1.
  - Stage 0 uses the effective carry-in.
- Skew and deskew:
  - Upper operand chunks are delayed in skew registers so chunk k reaches stage k k cycles after acceptance.
  - Lower result chunks are delayed in deskew registers so all chunks of one result emerge together.
- Per-stage valid bit travels with the data. No combinational path from a or b to sum.
- Latency: a beat accepted on cycle N (in_valid & in_ready) gives out_valid=1 with its result from cycle N+STAGES, given no stall.
- Throughput: one beat per cycle when out_ready is held high.
- Stall rule:
  - stall = out_valid & !out_ready.
  - While stalled, the whole pipeline (data, carries, valids) holds.
  - in_ready = !stall; this is the only combinational input-to-output path (out_ready → in_ready).
- Bubbles: when in_valid=0 on an advancing cycle, a bubble (valid=0) enters stage 0. Bubbles compress only by normal advance; no bubble collapsing.
- Handshake rules:
  - out_valid, sum, carry_out and overflow stay stable while out_valid=1 and out_ready=0.
  - Producer data is sampled only on in_valid & in_ready.
- Reset:
  - All valid bits are cleared. out_valid=0, sum=0, carry_out=0, overflow=0.
  - in_ready=1 from the first cycle after reset is deasserted.
  - Reset mid-operation discards every in-flight beat; no partial result is ever presented.
  - rst overrides a simultaneous accept: a beat offered on the reset cycle is dropped.
- STAGES=1 degenerates to a single registered adder with latency 1.
- STAGES=WIDTH gives a 1-bit-per-stage pipeline with latency WIDTH.

Test Plan (WIDTH=8, STAGES=4, CHUNK=2 unless noted):
- Carry ripple across all stages: a=0xFF, b=0x01, cin=0, sub=0 accepted at cycle 0, out_ready=1 -> at cycle 4: out_valid=1, sum=0x00, carry_out=1, overflow=0.
- Signed overflow plus subtract: a=0x7F+b=0x01 -> sum=0x80, ovf=1. Next cycle a=0x05, b=0x07, sub=1, cin=0 -> sum=0xFE, carry_out=0, ovf=0. Results on consecutive cycles 4 and 5.
- Throughput: 16 back-to-back random beats, out_ready=1 -> 16 consecutive out_valid cycles starting at cycle 4; every result matches the reference model; in_ready never drops.
- Backpressure: stream 6 beats and drop out_ready for 3 cycles when the first result appears -> sum held stable, in_ready=0 during the stall, no beat lost or duplicated, order preserved.
- Reset mid-flight: accept 3 beats, assert rst on cycle 2 for one cycle -> out_valid stays 0 for the next 4 cycles; a beat accepted after reset emerges 4 cycles later and is correct.
- Parameter sweep: STAGES ∈ {1,2,8}, WIDTH=8, plus WIDTH=32/STAGES=4 -> latency equals STAGES; exhaustive 8-bit add/sub with carry_in matches the reference model.
